// File: rtl/uart_tx_engine_if.sv
// Transmit-side signal bundle between the bus controller / baud generator and uart_tx_engine.
// The master side drives data, strobes and format; the engine (slave) drives txd and status.
interface uart_tx_engine_if;
  logic [7:0] tx_data_i;
  logic       tx_wr_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       stop2_i;
  logic       baud_tick_i;
  logic       baud_en_o;
  logic       txd_o;
  logic       tx_ready_o;
  logic       tx_busy_o;
  logic       tx_done_o;
  logic       tx_ovr_o;

  modport master (
    output tx_data_i, tx_wr_i, parity_en_i, parity_odd_i, stop2_i, baud_tick_i,
    input  baud_en_o, txd_o, tx_ready_o, tx_busy_o, tx_done_o, tx_ovr_o
  );

  modport slave (
    input  tx_data_i, tx_wr_i, parity_en_i, parity_odd_i, stop2_i, baud_tick_i,
    output baud_en_o, txd_o, tx_ready_o, tx_busy_o, tx_done_o, tx_ovr_o
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-entry holding register feeding an LSB-first serialiser that
// produces start / 8 data / optional parity / 1-or-2 stop frames, one bit per baud tick.
module uart_tx_engine (
  input logic             clk_i,
  input logic             rst_i,
  uart_tx_engine_if.slave tx
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d, sh_q, sh_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic       txd_q, txd_d, baud_en_q, baud_en_d, done_q, done_d, ovr_q, ovr_d;
  logic       ready_q, busy_q;
  logic       wr_ok, load, frame_end;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    txd_d       = txd_q;
    baud_en_d   = baud_en_q;
    done_d      = 1'b0;
    load        = 1'b0;
    frame_end   = 1'b0;
    wr_ok       = tx.tx_wr_i & ready_q;
    ovr_d       = ovr_q | (tx.tx_wr_i & ~ready_q);

    unique case (state_q)
      StIdle: begin
        txd_d     = 1'b1;
        baud_en_d = 1'b0;
        load      = hold_full_q;
      end
      StStart: begin
        if (tx.baud_tick_i) begin
          txd_d   = sh_q[0];
          cnt_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (tx.baud_tick_i) begin
          sh_d  = {1'b0, sh_q[7:1]};
          par_d = par_q ^ sh_q[0];
          if (cnt_q == 3'd7) begin
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = par_q ^ sh_q[0] ^ par_odd_q;
            end else begin
              state_d = StStop1;
              txd_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            txd_d = sh_q[1];
          end
        end
      end
      StParity: begin
        if (tx.baud_tick_i) begin
          state_d = StStop1;
          txd_d   = 1'b1;
        end
      end
      StStop1: begin
        if (tx.baud_tick_i) begin
          if (stop2_q) state_d = StStop2;
          else         frame_end = 1'b1;
        end
      end
      StStop2: begin
        frame_end = tx.baud_tick_i;
      end
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      done_d = 1'b1;
      if (hold_full_q) begin
        load = 1'b1;
      end else begin
        state_d   = StIdle;
        baud_en_d = 1'b0;
        txd_d     = 1'b1;
      end
    end

    // Format is captured with the byte so mid-frame changes cannot corrupt the frame.
    if (load) begin
      sh_d        = hold_q;
      hold_full_d = 1'b0;
      par_d       = 1'b0;
      par_en_d    = tx.parity_en_i;
      par_odd_d   = tx.parity_odd_i;
      stop2_d     = tx.stop2_i;
      state_d     = StStart;
      txd_d       = 1'b0;
      baud_en_d   = 1'b1;
    end

    if (wr_ok) begin
      hold_d      = tx.tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      sh_q        <= 8'h00;
      cnt_q       <= 3'd0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      txd_q       <= 1'b1;
      baud_en_q   <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      txd_q       <= txd_d;
      baud_en_q   <= baud_en_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= (state_d != StIdle) | hold_full_d;
    end
  end

  assign tx.txd_o      = txd_q;
  assign tx.baud_en_o  = baud_en_q;
  assign tx.tx_ready_o = ready_q;
  assign tx.tx_busy_o  = busy_q;
  assign tx.tx_done_o  = done_q;
  assign tx.tx_ovr_o   = ovr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of single frames plus back-to-back, overrun and
// reset sequences, with a behavioural baud generator driven by the engine's baud_en_o.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   brr = 4;
  int   bcnt = 1;
  logic force_tick = 1'b0;

  uart_tx_engine_if tx_if ();

  uart_tx_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .tx    (tx_if)
  );

  always #5 clk = ~clk;

  // Counter held at 1 while disabled; first tick BRR cycles after enable rises.
  assign tx_if.baud_tick_i = (tx_if.baud_en_o === 1'b1 && bcnt == brr) || force_tick;
  always_ff @(posedge clk) begin
    if (tx_if.baud_en_o !== 1'b1) bcnt <= 1;
    else if (bcnt == brr)         bcnt <= 1;
    else                          bcnt <= bcnt + 1;
  end

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        podd;
    logic        s2;
    int          brr;
    logic [11:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int total;
    brr = v.brr;
    tx_if.parity_en_i  = v.pen;
    tx_if.parity_odd_i = v.podd;
    tx_if.stop2_i      = v.s2;
    tx_if.tx_data_i    = v.data;
    tx_if.tx_wr_i      = 1'b1;
    step();
    tx_if.tx_wr_i   = 1'b0;
    tx_if.tx_data_i = ~v.data;
    check($sformatf("v%0d_ready_after_wr", idx), tx_if.tx_ready_o, 0);
    check($sformatf("v%0d_busy_after_wr", idx), tx_if.tx_busy_o, 1);
    check($sformatf("v%0d_txd_before_start", idx), tx_if.txd_o, 1);
    step();
    // Flip the format inputs after the byte is loaded; the frame must not change.
    tx_if.parity_en_i  = ~v.pen;
    tx_if.parity_odd_i = ~v.podd;
    tx_if.stop2_i      = ~v.s2;
    check($sformatf("v%0d_ready_at_load", idx), tx_if.tx_ready_o, 1);
    total = v.nbits * v.brr;
    for (int k = 0; k < total; k++) begin
      if (k != 0) step();
      check($sformatf("v%0d_txd_k%0d", idx, k), tx_if.txd_o, v.bits[k / v.brr]);
      check($sformatf("v%0d_en_done_k%0d", idx, k), {tx_if.baud_en_o, tx_if.tx_done_o}, 2'b10);
    end
    step();
    check($sformatf("v%0d_done_pulse", idx), tx_if.tx_done_o, 1);
    check($sformatf("v%0d_en_off", idx), tx_if.baud_en_o, 0);
    check($sformatf("v%0d_txd_idle", idx), tx_if.txd_o, 1);
    check($sformatf("v%0d_busy_off", idx), tx_if.tx_busy_o, 0);
    step();
    check($sformatf("v%0d_done_one_cycle", idx), tx_if.tx_done_o, 0);
  endtask

  initial begin
    logic [11:0] bits1, bits2;
    logic [7:0]  d34;
    logic        exp_txd;
    int          k, done_cnt, txd_low, en_cnt;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 4, 12'h2AA, 10};  // 8N1
    vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 3, 12'hE06, 12};  // 8O2
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 5, 12'h60E, 11};  // 8E1
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 4, 12'h34A, 10};  // 8N1
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 2, 12'hF00, 12};  // 8E2
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 3, 12'h600, 11};  // 8O1
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 2, 12'h5FE, 11};  // 8E1

    rst                = 1'b0;
    tx_if.tx_data_i    = 8'h00;
    tx_if.tx_wr_i      = 1'b0;
    tx_if.parity_en_i  = 1'b0;
    tx_if.parity_odd_i = 1'b0;
    tx_if.stop2_i      = 1'b0;

    // Reset then idle, with spurious ticks that must be ignored.
    step(); step(); step();
    check("rst_txd", tx_if.txd_o, 1);
    check("rst_ready", tx_if.tx_ready_o, 1);
    check("rst_busy", tx_if.tx_busy_o, 0);
    check("rst_done", tx_if.tx_done_o, 0);
    check("rst_ovr", tx_if.tx_ovr_o, 0);
    check("rst_baud_en", tx_if.baud_en_o, 0);
    rst = 1'b1;
    done_cnt = 0; txd_low = 0; en_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      force_tick = (i % 7 == 3);
      step();
      if (tx_if.tx_done_o !== 1'b0) done_cnt++;
      if (tx_if.txd_o !== 1'b1)     txd_low++;
      if (tx_if.baud_en_o !== 1'b0) en_cnt++;
    end
    force_tick = 1'b0;
    check("idle_done_count", done_cnt, 0);
    check("idle_txd_low_count", txd_low, 0);
    check("idle_baud_en_count", en_cnt, 0);
    check("idle_ready", tx_if.tx_ready_o, 1);

    for (int i = 0; i < 7; i++) run_frame(i, vecs[i]);

    // Back-to-back 8N1, BRR=4: 0xA5 then 0x3C with no gap.
    brr = 4;
    tx_if.parity_en_i = 1'b0; tx_if.parity_odd_i = 1'b0; tx_if.stop2_i = 1'b0;
    bits1 = 12'h34A;
    bits2 = 12'h278;
    tx_if.tx_data_i = 8'hA5; tx_if.tx_wr_i = 1'b1;
    step();
    tx_if.tx_wr_i = 1'b0;
    step();
    check("b2b_ready_k0", tx_if.tx_ready_o, 1);
    tx_if.tx_data_i = 8'h3C; tx_if.tx_wr_i = 1'b1;
    for (k = 0; k <= 80; k++) begin
      if (k != 0) step();
      if (k == 1) begin
        tx_if.tx_wr_i = 1'b0;
        check("b2b_ready_k1", tx_if.tx_ready_o, 0);
      end
      if (k < 40)      exp_txd = bits1[k / 4];
      else if (k < 80) exp_txd = bits2[(k - 40) / 4];
      else             exp_txd = 1'b1;
      check($sformatf("b2b_txd_k%0d", k), tx_if.txd_o, exp_txd);
      check($sformatf("b2b_done_k%0d", k), tx_if.tx_done_o, (k == 40 || k == 80));
      check($sformatf("b2b_en_k%0d", k), tx_if.baud_en_o, (k < 80));
    end
    step();

    // Overrun: third write while holding register full is dropped; then reset mid-DATA.
    d34 = 8'h34;
    tx_if.tx_data_i = 8'h12; tx_if.tx_wr_i = 1'b1;
    step();
    tx_if.tx_wr_i = 1'b0;
    step();
    k = 0;
    tx_if.tx_data_i = 8'h34; tx_if.tx_wr_i = 1'b1;
    step(); k++;
    check("ovr_ready_full", tx_if.tx_ready_o, 0);
    check("ovr_not_yet", tx_if.tx_ovr_o, 0);
    tx_if.tx_data_i = 8'hFF;
    step(); k++;
    tx_if.tx_wr_i = 1'b0;
    check("ovr_set", tx_if.tx_ovr_o, 1);
    while (k < 40) begin step(); k++; end
    check("ovr_second_start", tx_if.txd_o, 0);
    check("ovr_sticky", tx_if.tx_ovr_o, 1);
    for (int i = 0; i < 4; i++) begin
      while (k < 40 + 4 * (i + 1) + 2) begin step(); k++; end
      check($sformatf("ovr_data_bit%0d", i), tx_if.txd_o, d34[i]);
    end
    while (k < 61) begin step(); k++; end
    rst = 1'b0;
    step();
    check("midrst_txd", tx_if.txd_o, 1);
    check("midrst_ovr", tx_if.tx_ovr_o, 0);
    check("midrst_baud_en", tx_if.baud_en_o, 0);
    check("midrst_ready", tx_if.tx_ready_o, 1);
    check("midrst_busy", tx_if.tx_busy_o, 0);
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit engine sitting between the bus controller's transmit data register and the serial `txd` pin. It accepts bytes into a one-entry holding register and serialises them LSB-first as start / 8 data / optional parity / 1-or-2 stop frames. Bit timing comes from the UART baud generator: this block drives the generator's `enable_i` and advances one bit per `baud_clk_o` strobe.

## Interface
Parameters:
- none; the frame format is set by run-time inputs.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `tx_data_i` in 8: byte to transmit.
- `tx_wr_i` in 1: one-cycle write strobe for `tx_data_i`.
- `parity_en_i` in 1: 1 = insert a parity bit after the data bits.
- `parity_odd_i` in 1: 1 = odd parity, 0 = even parity.
- `stop2_i` in 1: 1 = two stop bits, 0 = one stop bit.
- `baud_tick_i` in 1: bit strobe, connected to the baud generator's `baud_clk_o`.
- `baud_en_o` out 1: registered; connected to the baud generator's `enable_i`.
- `txd_o` out 1: registered serial output; idle level is 1.
- `tx_ready_o` out 1: registered; 1 = holding register empty.
- `tx_busy_o` out 1: registered; 1 = a frame is in progress, or the holding register is full.
- `tx_done_o` out 1: one-cycle pulse when the final stop bit ends.
- `tx_ovr_o` out 1: sticky overrun flag; cleared only by reset.

## Operation
- Datapath: holding register `hold[7:0]` with a `hold_full` flag, plus shift register `sh[7:0]`, a 3-bit data bit counter and a parity accumulator.
- Write handling:
  - A write is accepted when `tx_wr_i` is high and `tx_ready_o` is high; accepting it sets `hold_full`.
  - When `tx_ready_o` is low, a write is dropped and `tx_ovr_o` is set.
- FSM states:
  - IDLE: `txd_o`=1, `baud_en_o`=0. If `hold_full`, move `hold` to `sh`, clear `hold_full`, go to START, and set `baud_en_o`=1 and `txd_o`=0.
  - START: on tick, `txd_o`=`sh[0]`, counter=0, go to DATA.
  - DATA: on tick, shift `sh` right and XOR the sent bit into parity. After bit 7, go to PARITY if `parity_en_i`, otherwise go to STOP1 with `txd_o`=1.
  - PARITY: `txd_o` = (XOR of the data bits) XOR `parity_odd_i`. On tick, go to STOP1 with `txd_o`=1.
  - STOP1: on tick, go to STOP2 if `stop2_i`, otherwise end the frame.
  - STOP2: on tick, end the frame.
- Frame end:
  - Pulse `tx_done_o`.
  - If `hold_full`, load `sh`, go straight to START with `txd_o`=0; `baud_en_o` stays 1 (back-to-back frames).
  - Otherwise go to IDLE with `baud_en_o`=0.
- Format inputs are sampled when `sh` is loaded and held for the whole frame; changes mid-frame have no effect.
- `tx_busy_o` = (state != IDLE) OR `hold_full`.

## Timing
- Reset values (while `rst_i`=0, at each clock edge): state IDLE, `txd_o`=1, `baud_en_o`=0, `tx_ready_o`=1, `tx_busy_o`=0, `tx_done_o`=0, `tx_ovr_o`=0, `hold_full`=0.
- Reset mid-frame aborts the frame; `txd_o` returns to 1 on the next edge.
- Baud generator behaviour: its counter is held at 1 while its enable is low. After `baud_en_o` rises, the first tick arrives BRR cycles after the edge that set `baud_en_o`, so every bit, including the start bit, lasts exactly BRR clocks.
- The baud generator divisor (BRR) must be ≥ 2. BRR=1 produces a constant tick and is unsupported.
- Latency: a write at edge W sets `hold_full` at W. IDLE acts on it at W+1, so `txd_o` falls at W+1.
- `tx_ready_o` rises at the edge where `hold` moves to `sh`.
- A write in the same cycle that `tx_ready_o` is low is dropped, even if the transfer happens at that edge.
- Frame length: (1 + 8 + P + S) × BRR clocks, where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- `baud_tick_i` is ignored in IDLE.

## Test plan
- Reset then idle: hold `rst_i`=0 for 3 cycles, then release -> `txd_o`=1, `tx_ready_o`=1, `baud_en_o`=0, no `tx_done_o` for 100 cycles.
- 8N1, BRR=4, write 0x55 -> `txd_o` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 clocks (40 clocks total); one `tx_done_o` pulse; `baud_en_o` falls on the same edge.
- 8O2, BRR=3, write 0x03 -> bits 0, 1,1,0,0,0,0,0,0, parity 1, stop 1,1; 36 clocks total.
- 8E1, BRR=5, write 0x07 -> parity bit 1; frame 55 clocks.
- Back-to-back, 8N1, BRR=4: write 0xA5, then write 0x3C while `tx_ready_o`=1 -> second start bit begins on the edge the first stop bit ends; `baud_en_o` never drops; two `tx_done_o` pulses 40 clocks apart.
- Overrun and reset: with a frame active and the holding register full, write 0xFF -> `tx_ovr_o`=1 and the byte is never sent. Assert reset mid-DATA -> `txd_o`=1 and `tx_ovr_o`=0 on the next edge.
